// File: rtl/fetch_decode_pipe.sv
// IF/ID boundary register: two-entry skid buffer on a valid/ready handshake with a registered in_ready.
// Optional upstream-stall counter is enabled by defining FETCH_DECODE_PERF_EN.
module fetch_decode_pipe #(
    parameter int                  INSTR_W   = 32,
    parameter int                  PC_W      = 32,
    parameter logic [PC_W-1:0]     RESET_PC  = PC_W'(32'h0000_3000),
    parameter logic [INSTR_W-1:0]  NOP_INSTR = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc4,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc4
`ifdef FETCH_DECODE_PERF_EN
    ,
    output logic [31:0]        stall_cycles
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [INSTR_W-1:0] main_instr, skid_instr;
    logic [PC_W-1:0]    main_pc4, skid_pc4;
    logic               accept, consume;
    logic               load_main_in, load_main_skid, load_skid;

    assign out_valid = (state != EMPTY);
    assign accept    = in_valid & in_ready;
    assign consume   = out_valid & out_ready;
    assign out_instr = main_instr;
    assign out_pc4   = main_pc4;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_nxt    = ONE;
                    load_main_in = 1'b1;
                end
            end
            ONE: begin
                if (accept && consume) begin
                    load_main_in = 1'b1;
                end else if (accept) begin
                    state_nxt = FULL;
                    load_skid = 1'b1;
                end else if (consume) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (consume) begin
                    state_nxt      = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        // A redirect discards everything, including a beat offered in the same cycle.
        if (flush) begin
            state_nxt      = EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
        end else begin
            state    <= state_nxt;
            in_ready <= (state_nxt != FULL);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_instr <= NOP_INSTR;
            main_pc4   <= RESET_PC;
        end else if (flush) begin
            main_instr <= NOP_INSTR;
        end else if (load_main_in) begin
            main_instr <= in_instr;
            main_pc4   <= in_pc4;
        end else if (load_main_skid) begin
            main_instr <= skid_instr;
            main_pc4   <= skid_pc4;
        end
    end

    // NOTE: skid data is never observed unless state says it is valid, so it carries no reset.
    always_ff @(posedge clk) begin
        if (load_skid) begin
            skid_instr <= in_instr;
            skid_pc4   <= in_pc4;
        end
    end

`ifdef FETCH_DECODE_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (in_valid && !in_ready && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule
